// File: rtl/elevator_pkg.sv
// Shared types for the SCAN elevator controller: FSM state encoding and
// direction constants.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_tick_timer.sv
// Counts enable ticks up to LIMIT-1; done pulses on the last tick and the
// count wraps to zero. clear forces the count back to zero.
module elevator_tick_timer #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic done
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  assign done = en && !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/elevator_scan_controller.sv
// Single-car SCAN elevator: latches calls, tracks half-floor position and
// serves floors in the current sweep direction before reversing.
module elevator_scan_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 6,
  parameter int TRAVEL_TICKS = 60,
  parameter int DWELL_TICKS  = 5,
  localparam int POS_W       = $clog2(2 * NUM_FLOORS - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [POS_W-1:0]      position,
  output logic                  direction,
  output logic                  moving,
  output logic                  door_open,
  output logic                  served,
  output logic [POS_W-2:0]      served_floor
);

  localparam logic [POS_W-1:0] MAX_POS = POS_W'(2 * (NUM_FLOORS - 1));

  state_t                  state, state_next;
  logic [NUM_FLOORS-1:0]   pending_next, clear_mask;
  logic [POS_W-1:0]        position_next, step_pos;
  logic                    direction_next;
  logic                    enter_door;
  logic [POS_W-2:0]        door_floor;
  logic                    travel_done, dwell_done, door_recall;

  // Per-floor masks relative to the current position and to the position
  // one half-step ahead in the travel direction.
  logic [NUM_FLOORS-1:0] above_cur, below_cur, at_cur;
  logic [NUM_FLOORS-1:0] above_step, below_step, at_step;
  logic                  ahead_cur, behind_cur, ahead_step, behind_step;

  assign step_pos = (direction == DIR_UP) ? position + 1'b1 : position - 1'b1;

  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
    localparam logic [POS_W-1:0] FLOOR_POS = POS_W'(2 * gi);
    assign above_cur[gi]  = FLOOR_POS > position;
    assign below_cur[gi]  = FLOOR_POS < position;
    assign at_cur[gi]     = FLOOR_POS == position;
    assign above_step[gi] = FLOOR_POS > step_pos;
    assign below_step[gi] = FLOOR_POS < step_pos;
    assign at_step[gi]    = FLOOR_POS == step_pos;
  end

  assign ahead_cur   = (direction == DIR_UP) ? |(pending & above_cur)  : |(pending & below_cur);
  assign behind_cur  = (direction == DIR_UP) ? |(pending & below_cur)  : |(pending & above_cur);
  assign ahead_step  = (direction == DIR_UP) ? |(pending & above_step) : |(pending & below_step);
  assign behind_step = (direction == DIR_UP) ? |(pending & below_step) : |(pending & above_step);

  // A new call for the floor whose door is open keeps the door open longer.
  assign door_recall = (state == DOOR) && |(call_req & at_cur);

  elevator_tick_timer #(.LIMIT(TRAVEL_TICKS)) u_travel (
    .clk   (clk),
    .rst   (rst),
    .en    (en && (state == MOVE)),
    .clear (state != MOVE),
    .done  (travel_done)
  );

  elevator_tick_timer #(.LIMIT(DWELL_TICKS)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .en    (en && (state == DOOR)),
    .clear ((state != DOOR) || door_recall),
    .done  (dwell_done)
  );

  always_comb begin
    state_next     = state;
    direction_next = direction;
    position_next  = position;
    clear_mask     = '0;
    enter_door     = 1'b0;
    door_floor     = position[POS_W-1:1];
    unique case (state)
      IDLE: begin
        if (en) begin
          if (|(pending & at_cur)) begin
            state_next = DOOR;
            enter_door = 1'b1;
            clear_mask = at_cur;
          end else if (ahead_cur) begin
            state_next = MOVE;
          end else if (behind_cur) begin
            direction_next = ~direction;
            state_next     = MOVE;
          end
        end
      end
      MOVE: begin
        if (travel_done) begin
          position_next = step_pos;
          if (!step_pos[0]) begin
            if (|(pending & at_step)) begin
              state_next = DOOR;
              enter_door = 1'b1;
              clear_mask = at_step;
              door_floor = step_pos[POS_W-1:1];
            end else if (!ahead_step) begin
              if (behind_step) direction_next = ~direction;
              else             state_next     = IDLE;
            end
          end
        end
      end
      DOOR: begin
        clear_mask = at_cur;
        if (!door_recall && dwell_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    pending_next = (pending | call_req) & ~clear_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= '0;
      position     <= '0;
      direction    <= DIR_UP;
      moving       <= 1'b0;
      door_open    <= 1'b0;
      served       <= 1'b0;
      served_floor <= '0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      position  <= position_next;
      direction <= direction_next;
      moving    <= (state_next == MOVE);
      door_open <= (state_next == DOOR);
      served    <= enter_door;
      if (enter_door) served_floor <= door_floor;
    end
  end

`ifndef SYNTHESIS
  step_in_range: assert property (@(posedge clk) disable iff (rst)
    travel_done |-> ((direction == DIR_UP) ? (position != MAX_POS) : (position != '0)));
`endif

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Bench for elevator_scan_controller: directed scenarios plus random traffic,
// all checked every cycle against a floor-level behavioural model.
module tb_elevator_scan_controller;

  localparam int NF = 6;
  localparam int TT = 4;
  localparam int DT = 2;
  localparam int PW = $clog2(2 * NF - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic [NF-1:0] call_req = '0;
  logic [NF-1:0] pending;
  logic [PW-1:0] position;
  logic          direction;
  logic          moving;
  logic          door_open;
  logic          served;
  logic [PW-2:0] served_floor;

  int total = 0;
  int bad = 0;

  elevator_scan_controller #(
    .NUM_FLOORS   (NF),
    .TRAVEL_TICKS (TT),
    .DWELL_TICKS  (DT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .call_req     (call_req),
    .pending      (pending),
    .position     (position),
    .direction    (direction),
    .moving       (moving),
    .door_open    (door_open),
    .served       (served),
    .served_floor (served_floor)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 travelling, 2 door open; timers count down.
  logic [NF-1:0] m_pend = '0;
  int m_pos = 0, m_dir = 1, m_mode = 0, m_tleft = TT, m_dleft = DT, m_sfloor = 0;
  bit m_served = 0;

  function automatic bit calls_beyond(int p, int d);
    for (int i = 0; i < NF; i++)
      if (m_pend[i] && ((d == 1) ? (2 * i > p) : (2 * i < p))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [NF-1:0] clr;
    int cur;
    bit sv;
    if (rst) begin
      m_pend = '0; m_pos = 0; m_dir = 1; m_mode = 0;
      m_tleft = TT; m_dleft = DT; m_served = 0; m_sfloor = 0;
      return;
    end
    clr = '0;
    sv = 1'b0;
    cur = m_pos / 2;
    case (m_mode)
      0: if (en) begin
        if (m_pos % 2 == 0 && m_pend[cur]) begin
          m_mode = 2; m_dleft = DT; clr[cur] = 1'b1; sv = 1'b1; m_sfloor = cur;
        end else if (calls_beyond(m_pos, m_dir)) begin
          m_mode = 1; m_tleft = TT;
        end else if (calls_beyond(m_pos, 1 - m_dir)) begin
          m_dir = 1 - m_dir; m_mode = 1; m_tleft = TT;
        end
      end
      1: if (en) begin
        m_tleft--;
        if (m_tleft == 0) begin
          m_tleft = TT;
          m_pos = m_pos + ((m_dir == 1) ? 1 : -1);
          if (m_pos % 2 == 0) begin
            if (m_pend[m_pos / 2]) begin
              m_mode = 2; m_dleft = DT; clr[m_pos / 2] = 1'b1; sv = 1'b1; m_sfloor = m_pos / 2;
            end else if (!calls_beyond(m_pos, m_dir)) begin
              if (calls_beyond(m_pos, 1 - m_dir)) m_dir = 1 - m_dir;
              else m_mode = 0;
            end
          end
        end
      end
      default: begin
        clr[cur] = 1'b1;
        if (call_req[cur]) m_dleft = DT;
        else if (en) begin
          m_dleft--;
          if (m_dleft == 0) m_mode = 0;
        end
      end
    endcase
    m_pend = (m_pend | call_req) & ~clr;
    m_served = sv;
  endtask

  task automatic compare_model();
    total++;
    if (pending !== m_pend || position !== PW'(m_pos) || direction !== 1'(m_dir) ||
        moving !== (m_mode == 1) || door_open !== (m_mode == 2) ||
        served !== m_served || served_floor !== (PW-1)'(m_sfloor)) begin
      bad++;
      $display("FAIL model t=%0t got pend=%b pos=%0d dir=%b mov=%b door=%b srv=%b sf=%0d want pend=%b pos=%0d dir=%0d mov=%0d door=%0d srv=%0d sf=%0d",
               $time, pending, position, direction, moving, door_open, served, served_floor,
               m_pend, m_pos, m_dir, m_mode == 1, m_mode == 2, m_served, m_sfloor);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
    if (served === 1'b1) $display("served floor %0d at t=%0t", served_floor, $time);
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic pulse(input logic [NF-1:0] c);
    call_req = c;
    tick();
    call_req = '0;
  endtask

  task automatic wait_served(input int want_floor, input string name);
    int n = 0;
    tick();
    while (served !== 1'b1 && n < 400) begin tick(); n++; end
    if (served !== 1'b1) check({name, "_timeout"}, 0, 1);
    else check(name, int'(served_floor), want_floor);
  endtask

  task automatic wait_pos(input int p, input string name);
    int n = 0;
    while (!(position == PW'(p) && moving === 1'b1) && n < 400) begin tick(); n++; end
    if (n >= 400) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((moving !== 1'b0 || door_open !== 1'b0) && n < 400) begin tick(); n++; end
    if (n >= 400) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int door_cycles, extra;

    tick();
    tick();
    check("rst_pending", int'(pending), 0);
    check("rst_position", int'(position), 0);
    check("rst_direction", int'(direction), 1);
    check("rst_moving", int'(moving), 0);
    check("rst_door", int'(door_open), 0);
    rst = 1'b0;

    // Single call to floor 3 from reset.
    pulse(6'b001000);
    check("t1_latched", int'(pending), 8);
    check("t1_not_moving_yet", int'(moving), 0);
    tick();
    check("t1_moving", int'(moving), 1);
    repeat (24) tick();
    check("t1_pos6", int'(position), 6);
    check("t1_served", int'(served), 1);
    check("t1_served_floor", int'(served_floor), 3);
    check("t1_pending_clear", int'(pending), 0);
    check("t1_door", int'(door_open), 1);
    tick();
    check("t1_door2", int'(door_open), 1);
    check("t1_served_once", int'(served), 0);
    tick();
    check("t1_door_closed", int'(door_open), 0);
    check("t1_idle", int'(moving), 0);

    // Park at floor 2 heading up, then calls above and below together.
    pulse(6'b000001);
    wait_served(0, "t2_park0");
    wait_idle("t2_idle0");
    pulse(6'b000100);
    wait_served(2, "t2_park2");
    wait_idle("t2_idle2");
    check("t2_dir_up", int'(direction), 1);
    pulse(6'b010001);
    wait_served(4, "t2_first4");
    check("t2_pend_after4", int'(pending), 1);
    wait_served(0, "t2_then0");
    check("t2_pend_after0", int'(pending), 0);
    wait_idle("t2_idle_end");

    // Call for floor 2 pulsed on the arrival edge, then a recall during DOOR.
    pulse(6'b000100);
    wait_pos(3, "t3_pos3");
    repeat (3) tick();
    pulse(6'b000100);
    check("t3_served", int'(served), 1);
    check("t3_served_floor", int'(served_floor), 2);
    check("t3_pend2_low", int'(pending[2]), 0);
    door_cycles = 1;
    extra = 0;
    pulse(6'b000100);
    for (int i = 0; i < 20 && door_open === 1'b1; i++) begin
      door_cycles++;
      if (served === 1'b1) extra++;
      tick();
    end
    check("t4_door_cycles", door_cycles, 3);
    check("t4_no_second_serve", extra, 0);
    check("t4_pend2_low", int'(pending[2]), 0);

    // en held low mid-travel while a call arrives.
    pulse(6'b010000);
    wait_pos(5, "t5_pos5");
    en = 1'b0;
    pulse(6'b100000);
    repeat (9) tick();
    check("t5_frozen_pos", int'(position), 5);
    check("t5_pending", int'(pending), 6'b110000);
    check("t5_still_moving", int'(moving), 1);
    en = 1'b1;
    wait_served(4, "t5_serve4");
    wait_served(5, "t5_serve5");
    wait_idle("t5_idle");

    // Reset in the middle of a trip.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse(6'b101000);
    wait_pos(2, "t6_pos2");
    check("t6_pending_pre", int'(pending), 6'b101000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_pos", int'(position), 0);
    check("t6_pending", int'(pending), 0);
    check("t6_moving", int'(moving), 0);
    check("t6_door", int'(door_open), 0);
    check("t6_dir", int'(direction), 1);

    // Random traffic with occasional en gaps and rare resets.
    for (int c = 0; c < 4000; c++) begin
      en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 1499) == 0);
      call_req = ($urandom_range(0, 7) == 0) ? (NF'($urandom) & NF'($urandom)) : '0;
      tick();
    end
    call_req = '0;
    rst = 1'b0;
    en = 1'b1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
